// File: rtl/pma_attr_checker.sv
// PMA attribute lookup: classifies a physical address as non-idempotent, executable and
// cacheable by scanning the configured region tables a fixed number of rules per cycle.
package cva6_config_pkg;
    localparam int unsigned MaxRules = 32'd16;
    localparam int unsigned RuleSelW = 32'd4;

    typedef struct packed {
        int unsigned                 PLEN;
        int unsigned                 NrNonIdempotentRules;
        logic [MaxRules-1:0][63:0]   NonIdempotentAddrBase;
        logic [MaxRules-1:0][63:0]   NonIdempotentLength;
        int unsigned                 NrExecuteRegionRules;
        logic [MaxRules-1:0][63:0]   ExecuteRegionAddrBase;
        logic [MaxRules-1:0][63:0]   ExecuteRegionLength;
        int unsigned                 NrCachedRegionRules;
        logic [MaxRules-1:0][63:0]   CachedRegionAddrBase;
        logic [MaxRules-1:0][63:0]   CachedRegionLength;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{PLEN: 32'd56, default: '0};
endpackage

module pma_attr_checker
    import cva6_config_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg       = cva6_cfg_empty,
    parameter int unsigned RulesPerCycle = 32'd4,
    parameter int unsigned IdWidth       = 32'd4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [CVA6Cfg.PLEN-1:0] req_paddr_i,
    input  logic [IdWidth-1:0]      req_id_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [IdWidth-1:0]      resp_id_o,
    output logic                    resp_nonidem_o,
    output logic                    resp_exec_o,
    output logic                    resp_cached_o
);

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Scan = 2'd1,
        Resp = 2'd2
    } state_e;

    localparam int unsigned NrNi   = CVA6Cfg.NrNonIdempotentRules;
    localparam int unsigned NrEx   = CVA6Cfg.NrExecuteRegionRules;
    localparam int unsigned NrCa   = CVA6Cfg.NrCachedRegionRules;
    localparam int unsigned NMaxA  = (NrNi > NrEx) ? NrNi : NrEx;
    localparam int unsigned NMax   = (NMaxA > NrCa) ? NMaxA : NrCa;
    localparam int unsigned ScanCycles = (NMax + RulesPerCycle - 32'd1) / RulesPerCycle;
    localparam int unsigned IdxW   = 32'd8;
    localparam state_e      FirstState = (ScanCycles == 32'd0) ? Resp : Scan;

    // 65-bit limit so a region ending at the top of the address space cannot wrap.
    function automatic logic rangeMatch(input logic [63:0] addr, input logic [63:0] base,
                                        input logic [63:0] len);
        logic [64:0] limit;
        limit = {1'b0, base} + {1'b0, len};
        return (addr >= base) && ({1'b0, addr} < limit);
    endfunction

    function automatic logic classHit(input logic [63:0] addr, input logic [31:0] idx,
                                      input int unsigned nr,
                                      input logic [MaxRules-1:0][63:0] bases,
                                      input logic [MaxRules-1:0][63:0] lens);
        logic        hit;
        logic [31:0] ruleIdx;
        hit = 1'b0;
        for (int unsigned k = 0; k < RulesPerCycle; k++) begin
            ruleIdx = idx + 32'(k);
            if ((ruleIdx < nr) &&
                rangeMatch(addr, bases[ruleIdx[RuleSelW-1:0]], lens[ruleIdx[RuleSelW-1:0]])) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    state_e            stateR;
    state_e            nextStateS;
    logic [63:0]       addrR;
    logic [IdWidth-1:0] idR;
    logic              niR;
    logic              exR;
    logic              caR;
    logic [IdxW-1:0]   idxR;
    logic              respValidR;
    logic              acceptS;
    logic              lastScanS;
    logic              hitNiS;
    logic              hitExS;
    logic              hitCaS;

    // Per-cycle rule window evaluation and handshake qualifiers.
    always_comb begin
        acceptS   = req_valid_i && req_ready_o;
        lastScanS = (32'(idxR) + RulesPerCycle) >= NMax;
        hitNiS    = classHit(addrR, 32'(idxR), NrNi, CVA6Cfg.NonIdempotentAddrBase,
                             CVA6Cfg.NonIdempotentLength);
        hitExS    = classHit(addrR, 32'(idxR), NrEx, CVA6Cfg.ExecuteRegionAddrBase,
                             CVA6Cfg.ExecuteRegionLength);
        hitCaS    = classHit(addrR, 32'(idxR), NrCa, CVA6Cfg.CachedRegionAddrBase,
                             CVA6Cfg.CachedRegionLength);
    end

    // State register; response valid tracks entry into Resp.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stateR     <= Idle;
            respValidR <= 1'b0;
        end else begin
            stateR     <= nextStateS;
            respValidR <= (nextStateS == Resp);
        end
    end

    // Next-state logic; flush overrides any accept or response handshake.
    always_comb begin
        nextStateS = stateR;
        if (flush_i) begin
            nextStateS = Idle;
        end else begin
            case (stateR)
                Idle: begin
                    if (acceptS) nextStateS = FirstState;
                    else         nextStateS = Idle;
                end
                Scan: begin
                    if (lastScanS) nextStateS = Resp;
                    else           nextStateS = Scan;
                end
                Resp: begin
                    if (acceptS)           nextStateS = FirstState;
                    else if (resp_ready_i) nextStateS = Idle;
                    else                   nextStateS = Resp;
                end
                default: nextStateS = Idle;
            endcase
        end
    end

    // Request ready decode.
    always_comb begin
        case (stateR)
            Idle:    req_ready_o = !flush_i;
            Resp:    req_ready_o = resp_ready_i && !flush_i;
            default: req_ready_o = 1'b0;
        endcase
    end

    // Address/tag capture and attribute accumulation; accumulators double as outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addrR <= 64'd0;
            idR   <= '0;
            niR   <= 1'b0;
            exR   <= 1'b0;
            caR   <= 1'b0;
            idxR  <= '0;
        end else if (flush_i) begin
            niR   <= 1'b0;
            exR   <= 1'b0;
            caR   <= 1'b0;
            idxR  <= '0;
        end else if (acceptS) begin
            addrR <= 64'(req_paddr_i);
            idR   <= req_id_i;
            niR   <= 1'b0;
            exR   <= 1'b0;
            caR   <= 1'b0;
            idxR  <= '0;
        end else if (stateR == Scan) begin
            niR   <= niR | hitNiS;
            exR   <= exR | hitExS;
            caR   <= caR | hitCaS;
            idxR  <= idxR + IdxW'(RulesPerCycle);
        end else begin
            idxR  <= idxR;
        end
    end

    assign resp_valid_o   = respValidR;
    assign resp_id_o      = idR;
    assign resp_nonidem_o = niR;
    assign resp_exec_o    = exR;
    assign resp_cached_o  = caR;

endmodule

// File: tb/tb_pma_attr_checker.sv
// Scoreboard bench for pma_attr_checker: three instances cover the main tables,
// a top-of-address-space region with empty tables, and fully empty tables.
module tb_pma_attr_checker;
    import cva6_config_pkg::*;

    function automatic cva6_cfg_t mainCfg();
        cva6_cfg_t c;
        c = cva6_cfg_empty;
        c.PLEN = 32'd64;
        c.NrNonIdempotentRules     = 32'd1;
        c.NonIdempotentAddrBase[0] = 64'h0;
        c.NonIdempotentLength[0]   = 64'h8000_0000;
        c.NrExecuteRegionRules     = 32'd2;
        c.ExecuteRegionAddrBase[0] = 64'h8000_0000;
        c.ExecuteRegionLength[0]   = 64'h4000_0000;
        c.ExecuteRegionAddrBase[1] = 64'h1_0000;
        c.ExecuteRegionLength[1]   = 64'h1_0000;
        c.NrCachedRegionRules      = 32'd1;
        c.CachedRegionAddrBase[0]  = 64'h8000_0000;
        c.CachedRegionLength[0]    = 64'h4000_0000;
        return c;
    endfunction

    function automatic cva6_cfg_t ovfCfg();
        cva6_cfg_t c;
        c = cva6_cfg_empty;
        c.PLEN = 32'd64;
        c.NrNonIdempotentRules     = 32'd1;
        c.NonIdempotentAddrBase[0] = 64'hFFFF_FFFF_FFFF_FFF0;
        c.NonIdempotentLength[0]   = 64'h20;
        return c;
    endfunction

    function automatic cva6_cfg_t emptyCfg();
        cva6_cfg_t c;
        c = cva6_cfg_empty;
        c.PLEN = 32'd64;
        return c;
    endfunction

    localparam cva6_cfg_t MainCfg  = mainCfg();
    localparam cva6_cfg_t OvfCfg   = ovfCfg();
    localparam cva6_cfg_t EmptyCfg = emptyCfg();

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid [3];
    logic        flush [3];
    logic        respReady [3];
    logic [63:0] paddr [3];
    logic [3:0]  reqId [3];
    logic        reqReady [3];
    logic        respValid [3];
    logic [3:0]  respId [3];
    logic        respNi [3];
    logic        respEx [3];
    logic        respCa [3];

    always #5 clk = ~clk;

    pma_attr_checker #(.CVA6Cfg(MainCfg), .RulesPerCycle(32'd1), .IdWidth(32'd4)) dutMain (
        .clk_i(clk), .rst_i(rst), .flush_i(flush[0]), .req_valid_i(reqValid[0]),
        .req_ready_o(reqReady[0]), .req_paddr_i(paddr[0]), .req_id_i(reqId[0]),
        .resp_valid_o(respValid[0]), .resp_ready_i(respReady[0]), .resp_id_o(respId[0]),
        .resp_nonidem_o(respNi[0]), .resp_exec_o(respEx[0]), .resp_cached_o(respCa[0]));

    pma_attr_checker #(.CVA6Cfg(OvfCfg), .RulesPerCycle(32'd1), .IdWidth(32'd4)) dutOvf (
        .clk_i(clk), .rst_i(rst), .flush_i(flush[1]), .req_valid_i(reqValid[1]),
        .req_ready_o(reqReady[1]), .req_paddr_i(paddr[1]), .req_id_i(reqId[1]),
        .resp_valid_o(respValid[1]), .resp_ready_i(respReady[1]), .resp_id_o(respId[1]),
        .resp_nonidem_o(respNi[1]), .resp_exec_o(respEx[1]), .resp_cached_o(respCa[1]));

    pma_attr_checker #(.CVA6Cfg(EmptyCfg), .RulesPerCycle(32'd1), .IdWidth(32'd4)) dutEmpty (
        .clk_i(clk), .rst_i(rst), .flush_i(flush[2]), .req_valid_i(reqValid[2]),
        .req_ready_o(reqReady[2]), .req_paddr_i(paddr[2]), .req_id_i(reqId[2]),
        .resp_valid_o(respValid[2]), .resp_ready_i(respReady[2]), .resp_id_o(respId[2]),
        .resp_nonidem_o(respNi[2]), .resp_exec_o(respEx[2]), .resp_cached_o(respCa[2]));

    typedef struct {
        int       d;
        logic [3:0] id;
        logic     ni;
        logic     ex;
        logic     ca;
        int       lat;
    } exp_t;

    exp_t sbQ[$];
    exp_t lastE;
    int   assertCount = 0;
    int   failCount   = 0;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pushExp(input int d, input logic [3:0] id, input logic ni, input logic ex,
                           input logic ca, input int lat);
        exp_t e;
        e.d = d; e.id = id; e.ni = ni; e.ex = ex; e.ca = ca; e.lat = lat;
        sbQ.push_back(e);
    endtask

    task automatic drive(input int d, input logic [63:0] a, input logic [3:0] id);
        @(negedge clk);
        reqValid[d] = 1'b1;
        paddr[d]    = a;
        reqId[d]    = id;
        #1 checkEq("reqReady", 64'(reqReady[d]), 64'd1);
        @(negedge clk);
        reqValid[d] = 1'b0;
    endtask

    // Called at the first negedge after the accepting posedge.
    task automatic waitResp();
        int cyc;
        if (sbQ.size() == 0) begin
            checkEq("sbEmpty", 64'(sbQ.size()), 64'd1);
        end else begin
            lastE = sbQ.pop_front();
            cyc = 1;
            while (!respValid[lastE.d] && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            checkEq("latency",   64'(cyc), 64'(lastE.lat));
            checkEq("respValid", 64'(respValid[lastE.d]), 64'd1);
            checkEq("respId",    64'(respId[lastE.d]), 64'(lastE.id));
            checkEq("nonidem",   64'(respNi[lastE.d]), 64'(lastE.ni));
            checkEq("exec",      64'(respEx[lastE.d]), 64'(lastE.ex));
            checkEq("cached",    64'(respCa[lastE.d]), 64'(lastE.ca));
        end
    endtask

    task automatic lookup(input int d, input logic [63:0] a, input logic [3:0] id,
                          input logic ni, input logic ex, input logic ca, input int lat);
        pushExp(d, id, ni, ex, ca, lat);
        drive(d, a, id);
        waitResp();
    endtask

    initial begin
        logic sawValid;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            reqValid[i] = 1'b0; flush[i] = 1'b0; respReady[i] = 1'b1;
            paddr[i] = 64'd0; reqId[i] = 4'd0;
        end
        #1;
        checkEq("rstReady",   64'(reqReady[0]), 64'd1);
        checkEq("rstValid",   64'(respValid[0]), 64'd0);
        checkEq("rstId",      64'(respId[0]), 64'd0);
        checkEq("rstAttrs",   64'({respNi[0], respEx[0], respCa[0]}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic lookup and region boundaries on the main tables.
        lookup(0, 64'h8000_1000, 4'd3, 1'b0, 1'b1, 1'b1, 3);
        lookup(0, 64'hBFFF_FFFF, 4'd4, 1'b0, 1'b1, 1'b1, 3);
        lookup(0, 64'hC000_0000, 4'd5, 1'b0, 1'b0, 1'b0, 3);
        lookup(0, 64'h7FFF_FFFF, 4'd6, 1'b1, 1'b0, 1'b0, 3);
        lookup(0, 64'h0001_0000, 4'd7, 1'b1, 1'b1, 1'b0, 3);
        lookup(0, 64'h0002_0000, 4'd8, 1'b1, 1'b0, 1'b0, 3);

        // Region touching the top of the address space; empty tables.
        lookup(1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 1'b1, 1'b0, 1'b0, 2);
        lookup(1, 64'hFFFF_FFFF_FFFF_FFEF, 4'd2, 1'b0, 1'b0, 1'b0, 2);
        lookup(2, 64'h8000_1000,           4'd9, 1'b0, 1'b0, 1'b0, 1);

        // Backpressure, then back-to-back accept during the response handshake.
        @(negedge clk);
        respReady[0] = 1'b0;
        pushExp(0, 4'd2, 1'b0, 1'b1, 1'b1, 3);
        drive(0, 64'h8000_0000, 4'd2);
        waitResp();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkEq("holdValid", 64'(respValid[0]), 64'd1);
            checkEq("holdId",    64'(respId[0]), 64'd2);
            checkEq("holdAttrs", 64'({respNi[0], respEx[0], respCa[0]}), 64'b011);
        end
        respReady[0] = 1'b1;
        reqValid[0]  = 1'b1;
        paddr[0]     = 64'h1_8000;
        reqId[0]     = 4'd10;
        #1 checkEq("b2bReady", 64'(reqReady[0]), 64'd1);
        pushExp(0, 4'd10, 1'b1, 1'b1, 1'b0, 3);
        @(negedge clk);
        reqValid[0] = 1'b0;
        waitResp();

        // Flush one cycle after accept.
        drive(0, 64'h8000_1000, 4'd11);
        flush[0] = 1'b1;
        @(negedge clk);
        flush[0] = 1'b0;
        sawValid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sawValid = sawValid | respValid[0];
            @(negedge clk);
        end
        checkEq("flushNoResp", 64'(sawValid), 64'd0);
        checkEq("flushIdle",   64'(reqReady[0]), 64'd1);

        // Flush together with a request: not accepted.
        flush[0]    = 1'b1;
        reqValid[0] = 1'b1;
        paddr[0]    = 64'h8000_1000;
        reqId[0]    = 4'd12;
        #1 checkEq("flushReady", 64'(reqReady[0]), 64'd0);
        @(negedge clk);
        flush[0]    = 1'b0;
        reqValid[0] = 1'b0;
        sawValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sawValid = sawValid | respValid[0];
            @(negedge clk);
        end
        checkEq("flushReqNoResp", 64'(sawValid), 64'd0);
        checkEq("flushReqIdle",   64'(reqReady[0]), 64'd1);

        // Asynchronous reset in the middle of a scan.
        drive(0, 64'h8000_1000, 4'd13);
        #2 rst = 1'b1;
        #1;
        checkEq("arstValid", 64'(respValid[0]), 64'd0);
        checkEq("arstReady", 64'(reqReady[0]), 64'd1);
        checkEq("arstId",    64'(respId[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        lookup(0, 64'h8000_1000, 4'd12, 1'b0, 1'b1, 1'b1, 3);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
